// File: rtl/calc_seq_top.sv
// calc_seq_top: sequential signed calculator with 7-segment readout.
//
// A start in IDLE latches a, b and the operation. EXEC computes the result
// (one cycle for add/sub/mul, WIDTH cycles of restoring division for div).
// CONV then runs 2*WIDTH cycles of double-dabble on |result|, |a| and |b|
// in parallel. The displayed registers update together on the CONV->DONE
// edge, so a reset mid-calculation leaves no partial update.
//
// Ports:
//   clk, rst_n  clock (rising edge), async active-low reset
//   a, b        signed operands (WIDTH bits)
//   func        [1:0] op (add/sub/mul/div), [2] display select (1 = operands)
//   start       request a calculation (sampled in IDLE only)
//   out         result, or {a_lat, b_lat} when func[2]=1
//   segs        active-low 7-segment patterns, bit 7i+j = segment j of HEX i
//   err         divide-by-zero flag of the last completed operation
//   busy        calculation in progress (EXEC, CONV, DONE)
//   done        one-cycle completion pulse
module calc_seq_top #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned N_SEGS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [2:0]            func,
  input  logic                  start,
  output logic [2*WIDTH-1:0]    out,
  output logic [7*N_SEGS-1:0]   segs,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  function automatic int unsigned dec_digits(input int unsigned p);
    longint unsigned v;
    int unsigned     n;
    v = 64'd1 << p;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

  localparam int unsigned RD = dec_digits(2 * WIDTH - 1);
  localparam int unsigned OD = dec_digits(WIDTH - 1);
  localparam int unsigned RW = 2 * WIDTH;
  localparam int unsigned BW = 4 * RD;
  localparam int unsigned OW = 4 * OD;
  localparam int unsigned CW = $clog2(RW);

  if ((RD + 1 > N_SEGS) || (OD + 1 > N_SEGS / 2)) begin : g_bad_params
    $error("calc_seq_top: N_SEGS too small for WIDTH");
  end

  localparam logic [CW-1:0] CntDivLast  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CntConvLast = CW'(RW - 1);
  localparam logic [1:0]    OpDiv       = 2'b11;
  localparam logic [6:0]    SegBlank    = 7'b1111111;
  localparam logic [6:0]    SegMinus    = 7'b0111111;

  typedef enum logic [1:0] {StIdle, StExec, StConv, StDone} state_e;

  state_e state_q, state_d;
  logic   exec_last, conv_last;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_lat, b_lat;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] div_q_q, div_r_q;
  logic [RW-1:0]    res_work_q;
  logic             err_work_q;
  logic [RW-1:0]    res_bin_q, a_bin_q, b_bin_q;
  logic [BW-1:0]    res_dd_q, res_bcd_q;
  logic [OW-1:0]    a_dd_q, b_dd_q, a_bcd_q, b_bcd_q;
  logic [RW-1:0]    result_q;
  logic             err_q, res_neg_q, a_neg_q, b_neg_q, shown_q;

  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Unsigned magnitude; the most negative value maps to 2^(RW-1) correctly.
  function automatic logic [RW-1:0] mag_2w(input logic [RW-1:0] v);
    return v[RW-1] ? -v : v;
  endfunction

  function automatic logic [BW-1:0] dd_res(input logic [BW-1:0] d, input logic bit_in);
    logic [BW-1:0] t;
    t = d;
    for (int i = 0; i < int'(RD); i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[BW-2:0], bit_in};
  endfunction

  function automatic logic [OW-1:0] dd_op(input logic [OW-1:0] d, input logic bit_in);
    logic [OW-1:0] t;
    t = d;
    for (int i = 0; i < int'(OD); i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[OW-2:0], bit_in};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SegBlank;
    endcase
  endfunction

  // Restoring division step on magnitudes; div_q_q starts as |a| and
  // accumulates quotient bits from the right.
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   div_r_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_r_next, div_q_next;

  always_comb begin
    b_mag       = mag_w(b_lat);
    div_r_shift = {div_r_q, div_q_q[WIDTH-1]};
    div_diff    = div_r_shift - {1'b0, b_mag};
    div_ge      = !div_diff[WIDTH];
    div_r_next  = div_ge ? div_diff[WIDTH-1:0] : div_r_shift[WIDTH-1:0];
    div_q_next  = {div_q_q[WIDTH-2:0], div_ge};
  end

  logic [RW-1:0] a_ext, b_ext, q_ext, exec_res;
  logic          exec_err;

  always_comb begin
    a_ext    = {{WIDTH{a_lat[WIDTH-1]}}, a_lat};
    b_ext    = {{WIDTH{b_lat[WIDTH-1]}}, b_lat};
    q_ext    = {{WIDTH{1'b0}}, div_q_next};
    exec_err = 1'b0;
    case (op_q)
      2'b00:   exec_res = a_ext + b_ext;
      2'b01:   exec_res = a_ext - b_ext;
      2'b10:   exec_res = a_ext * b_ext;
      default: begin
        if (b_lat == '0) begin
          exec_res = '0;
          exec_err = 1'b1;
        end else begin
          exec_res = (a_lat[WIDTH-1] ^ b_lat[WIDTH-1]) ? -q_ext : q_ext;
        end
      end
    endcase
  end

  logic [BW-1:0] res_dd_next;
  logic [OW-1:0] a_dd_next, b_dd_next;

  always_comb begin
    res_dd_next = dd_res(res_dd_q, res_bin_q[RW-1]);
    a_dd_next   = dd_op(a_dd_q, a_bin_q[RW-1]);
    b_dd_next   = dd_op(b_dd_q, b_bin_q[RW-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    exec_last = 1'b0;
    conv_last = 1'b0;
    case (state_q)
      StIdle: if (start) state_d = StExec;
      StExec: begin
        if (op_q != OpDiv || cnt_q == CntDivLast) begin
          exec_last = 1'b1;
          state_d   = StConv;
        end
      end
      StConv: begin
        if (cnt_q == CntConvLast) begin
          conv_last = 1'b1;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      op_q       <= '0;
      div_q_q    <= '0;
      div_r_q    <= '0;
      res_work_q <= '0;
      err_work_q <= 1'b0;
      res_bin_q  <= '0;
      a_bin_q    <= '0;
      b_bin_q    <= '0;
      res_dd_q   <= '0;
      a_dd_q     <= '0;
      b_dd_q     <= '0;
      res_bcd_q  <= '0;
      a_bcd_q    <= '0;
      b_bcd_q    <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      res_neg_q  <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      shown_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_lat   <= a;
            b_lat   <= b;
            op_q    <= func[1:0];
            div_q_q <= mag_w(a);
            div_r_q <= '0;
            cnt_q   <= '0;
          end
        end
        StExec: begin
          if (op_q == OpDiv) begin
            div_q_q <= div_q_next;
            div_r_q <= div_r_next;
            cnt_q   <= cnt_q + CW'(1);
          end
          if (exec_last) begin
            res_work_q <= exec_res;
            err_work_q <= exec_err;
            res_bin_q  <= mag_2w(exec_res);
            a_bin_q    <= {{WIDTH{1'b0}}, mag_w(a_lat)};
            b_bin_q    <= {{WIDTH{1'b0}}, b_mag};
            res_dd_q   <= '0;
            a_dd_q     <= '0;
            b_dd_q     <= '0;
            cnt_q      <= '0;
          end
        end
        StConv: begin
          res_bin_q <= res_bin_q << 1;
          a_bin_q   <= a_bin_q << 1;
          b_bin_q   <= b_bin_q << 1;
          res_dd_q  <= res_dd_next;
          a_dd_q    <= a_dd_next;
          b_dd_q    <= b_dd_next;
          cnt_q     <= cnt_q + CW'(1);
          if (conv_last) begin
            result_q  <= res_work_q;
            err_q     <= err_work_q;
            res_bcd_q <= res_dd_next;
            a_bcd_q   <= a_dd_next;
            b_bcd_q   <= b_dd_next;
            res_neg_q <= res_work_q[RW-1];
            a_neg_q   <= a_lat[WIDTH-1];
            b_neg_q   <= b_lat[WIDTH-1];
            shown_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign err  = err_q;
  assign out  = func[2] ? {a_lat, b_lat} : result_q;

  for (genvar i = 0; i < N_SEGS; i++) begin : g_hex
    logic [6:0] res_pat, op_pat;

    if (i < RD) begin : g_res_dig
      assign res_pat = seg7(res_bcd_q[4*i +: 4]);
    end else if (i == RD) begin : g_res_sign
      assign res_pat = res_neg_q ? SegMinus : SegBlank;
    end else begin : g_res_blank
      assign res_pat = SegBlank;
    end

    if (i < OD) begin : g_b_dig
      assign op_pat = seg7(b_bcd_q[4*i +: 4]);
    end else if (i == OD) begin : g_b_sign
      assign op_pat = b_neg_q ? SegMinus : SegBlank;
    end else if (i >= N_SEGS / 2 && i < N_SEGS / 2 + OD) begin : g_a_dig
      assign op_pat = seg7(a_bcd_q[4*(i-N_SEGS/2) +: 4]);
    end else if (i == N_SEGS / 2 + OD) begin : g_a_sign
      assign op_pat = a_neg_q ? SegMinus : SegBlank;
    end else begin : g_op_blank
      assign op_pat = SegBlank;
    end

    assign segs[7*i +: 7] = !shown_q ? SegBlank : (func[2] ? op_pat : res_pat);
  end

endmodule

// File: tb/tb_calc_seq_top.sv
module tb_calc_seq_top;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;

  logic        clk;
  logic        rst_n;
  logic [5:0]  a, b;
  logic [2:0]  func;
  logic        start;
  logic [11:0] out;
  logic [55:0] segs;
  logic        err, busy, done;

  int checks;
  int failures;

  calc_seq_top #(
    .WIDTH  (6),
    .N_SEGS (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .func  (func),
    .start (start),
    .out   (out),
    .segs  (segs),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hx(input int i);
    return segs[7*i +: 7];
  endfunction

  // Issues one start and returns the number of edges after the start edge
  // until done is first seen high (-1 if it never comes).
  task automatic run_op(input logic [5:0] ai, input logic [5:0] bi, input logic [2:0] fi,
                        output int lat);
    a = ai;
    b = bi;
    func = fi;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a = 6'd0; b = 6'd0; func = 3'b000; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (out !== 12'h000) begin failures++; $display("FAIL reset_out got=%h want=000", out); end
    checks++; if (segs !== {56{1'b1}}) begin failures++; $display("FAIL reset_segs got=%h want=all ones", segs); end
    func = 3'b100; #1;
    checks++; if (out !== 12'h000) begin failures++; $display("FAIL reset_out_ops got=%h want=000", out); end
    checks++; if (segs !== {56{1'b1}}) begin failures++; $display("FAIL reset_segs_ops got=%h want=all ones", segs); end
    func = 3'b000;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_add;
    int lat;
    logic [6:0] exp [8];
    exp = '{D2, D0, D0, D0, BL, BL, BL, BL};
    a = 6'd5; b = 6'h3D; func = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%b want=1", busy); end
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat !== 13) begin failures++; $display("FAIL add_latency got=%0d want=13", lat); end
    checks++; if (out !== 12'h002) begin failures++; $display("FAIL add_out got=%h want=002", out); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL add_err got=%b want=0", err); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hx(i) !== exp[i]) begin failures++; $display("FAIL add_hex%0d got=%b want=%b", i, hx(i), exp[i]); end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_width got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_mul_operands;
    int lat;
    logic [6:0] expr [8];
    logic [6:0] expo [8];
    expr = '{D4, D2, D0, D1, BL, BL, BL, BL};
    expo = '{D2, D3, MI, BL, D2, D3, MI, BL};
    run_op(6'h20, 6'h20, 3'b010, lat);
    checks++; if (lat !== 13) begin failures++; $display("FAIL mul_latency got=%0d want=13", lat); end
    checks++; if (out !== 12'h400) begin failures++; $display("FAIL mul_out got=%h want=400", out); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hx(i) !== expr[i]) begin failures++; $display("FAIL mul_hex%0d got=%b want=%b", i, hx(i), expr[i]); end
    end
    func = 3'b110; #1;
    checks++; if (out !== 12'h820) begin failures++; $display("FAIL ops_out got=%h want=820", out); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hx(i) !== expo[i]) begin failures++; $display("FAIL ops_hex%0d got=%b want=%b", i, hx(i), expo[i]); end
    end
    func = 3'b010;
    @(posedge clk); #1;
  endtask

  task automatic test_div;
    int lat;
    logic [6:0] exp [8];
    exp = '{D7, D0, D0, D0, MI, BL, BL, BL};
    run_op(6'h21, 6'd4, 3'b011, lat);
    checks++; if (lat !== 18) begin failures++; $display("FAIL div_latency got=%0d want=18", lat); end
    checks++; if (out !== 12'hFF9) begin failures++; $display("FAIL div_out got=%h want=ff9", out); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL div_err got=%b want=0", err); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hx(i) !== exp[i]) begin failures++; $display("FAIL div_hex%0d got=%b want=%b", i, hx(i), exp[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int lat;
    logic [6:0] exp [8];
    exp = '{D0, D0, D0, D0, BL, BL, BL, BL};
    run_op(6'd9, 6'd0, 3'b011, lat);
    checks++; if (lat !== 18) begin failures++; $display("FAIL divz_latency got=%0d want=18", lat); end
    checks++; if (out !== 12'h000) begin failures++; $display("FAIL divz_out got=%h want=000", out); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL divz_err got=%b want=1", err); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hx(i) !== exp[i]) begin failures++; $display("FAIL divz_hex%0d got=%b want=%b", i, hx(i), exp[i]); end
    end
    @(posedge clk); #1;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL divz_err_hold got=%b want=1", err); end
    run_op(6'd1, 6'd2, 3'b000, lat);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL divz_err_clear got=%b want=0", err); end
    checks++; if (out !== 12'h003) begin failures++; $display("FAIL divz_next_out got=%h want=003", out); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    int ndone;
    logic [6:0] exp [8];
    exp = '{D7, D1, D0, D0, BL, BL, BL, BL};
    a = 6'd10; b = 6'd7; func = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        a = 6'h3F; b = 6'h3F; func = 3'b010; start = 1'b1;
      end
      @(posedge clk); #1;
      if (k == 5) begin
        start = 1'b0;
        func = 3'b000;
      end
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          checks++;
          if (out !== 12'h011) begin failures++; $display("FAIL b2b_out got=%h want=011", out); end
          for (int i = 0; i < 8; i++) begin
            checks++;
            if (hx(i) !== exp[i]) begin failures++; $display("FAIL b2b_hex%0d got=%b want=%b", i, hx(i), exp[i]); end
          end
        end
      end
    end
    checks++; if (lat !== 13) begin failures++; $display("FAIL b2b_latency got=%0d want=13", lat); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL b2b_done_count got=%0d want=1", ndone); end
  endtask

  task automatic test_reset_conv;
    int lat;
    int ndone;
    logic [6:0] exp [8];
    exp = '{D5, D0, D0, D0, BL, BL, BL, BL};
    a = 6'd3; b = 6'd4; func = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rconv_busy_before got=%b want=1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rconv_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rconv_done got=%b want=0", done); end
    checks++; if (out !== 12'h000) begin failures++; $display("FAIL rconv_out got=%h want=000", out); end
    checks++; if (segs !== {56{1'b1}}) begin failures++; $display("FAIL rconv_segs got=%h want=all ones", segs); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL rconv_no_done got=%0d want=0", ndone); end
    checks++; if (segs !== {56{1'b1}}) begin failures++; $display("FAIL rconv_segs_hold got=%h want=all ones", segs); end
    run_op(6'd2, 6'd3, 3'b000, lat);
    checks++; if (lat !== 13) begin failures++; $display("FAIL rconv_next_latency got=%0d want=13", lat); end
    checks++; if (out !== 12'h005) begin failures++; $display("FAIL rconv_next_out got=%h want=005", out); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (hx(i) !== exp[i]) begin failures++; $display("FAIL rconv_hex%0d got=%b want=%b", i, hx(i), exp[i]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    a = '0; b = '0; func = '0; start = 1'b0;
    test_reset;
    test_add;
    test_mul_operands;
    test_div;
    test_div_zero;
    test_back_to_back;
    test_reset_conv;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
